// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the byte-wide memory port arbiter.
// master = requesters plus RAM model, slave = the arbiter itself.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              rdy;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport master (
    output rdy, if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output ram_din,
    input  if_done, if_rdata, mem_done, mem_rdata,
    input  ram_a, ram_wr, ram_dout
  );

  modport slave (
    input  rdy, if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  ram_din,
    output if_done, if_rdata, mem_done, mem_rdata,
    output ram_a, ram_wr, ram_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch (word reads) and
// load/store (1/2/4-byte reads and writes); MEM wins, a branch flush aborts a fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e            state_q;
  logic              owner_mem_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issue_q;
  logic [CNT_W-1:0]  cap_q;
  logic              pres_q;
  logic              lat_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic              ram_wr_q;
  logic [7:0]        ram_dout_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic              take_mem_c;
  logic              take_if_c;
  logic              flush_c;
  logic [CNT_W-1:0]  mem_n_c;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W-1:0] nxt_addr_c;
  logic [CNT_W-1:0]  cap_d;
  logic [DATA_W-1:0] rbuf_d;

  // Acceptance, pointer advance and byte-lane assembly
  always_comb begin
    mem_n_c    = CNT_W'(4);
    take_mem_c = 1'b0;
    take_if_c  = 1'b0;
    flush_c    = 1'b0;
    base_c     = bus.if_addr;
    nxt_addr_c = base_q + ADDR_W'(issue_q);
    cap_d      = cap_q;
    rbuf_d     = rbuf_q;

    case (bus.mem_len)
      2'd0:    mem_n_c = CNT_W'(1);
      2'd1:    mem_n_c = CNT_W'(2);
      default: mem_n_c = CNT_W'(4);
    endcase

    take_mem_c = (state_q == IDLE) && bus.rdy && bus.mem_req && !mem_done_q;
    take_if_c  = (state_q == IDLE) && bus.rdy && !take_mem_c && bus.if_req &&
                 !bus.if_flush && !if_done_q;
    if (take_mem_c) base_c = bus.mem_addr;

    flush_c = (state_q == READ) && !owner_mem_q && bus.if_flush;

    // A read counts a byte when it lands on ram_din; a write when its strobe retires
    if (state_q == READ) cap_d = cap_q + CNT_W'(lat_q);
    else                 cap_d = cap_q + CNT_W'(ram_wr_q);
    if (lat_q) rbuf_d[{cap_q[1:0], 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      len_q       <= '0;
      issue_q     <= '0;
      cap_q       <= '0;
      pres_q      <= 1'b0;
      lat_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      ram_wr_q   <= 1'b0;

      if (flush_c) begin
        state_q <= IDLE;
        pres_q  <= 1'b0;
        lat_q   <= 1'b0;
      end else if (!bus.rdy) begin
        // Pause: the byte on ram_din is discarded and re-requested on resume
        issue_q <= cap_q;
        pres_q  <= 1'b0;
        lat_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (take_mem_c || take_if_c) begin
              owner_mem_q <= take_mem_c;
              len_q       <= take_mem_c ? mem_n_c : CNT_W'(4);
              base_q      <= base_c;
              ram_a_q     <= base_c;
              wdata_q     <= bus.mem_wdata;
              rbuf_q      <= '0;
              cap_q       <= '0;
              issue_q     <= CNT_W'(1);
              lat_q       <= 1'b0;
              if (take_mem_c && bus.mem_we) begin
                state_q    <= WRITE;
                ram_wr_q   <= 1'b1;
                ram_dout_q <= bus.mem_wdata[7:0];
                pres_q     <= 1'b0;
              end else begin
                state_q <= READ;
                pres_q  <= 1'b1;
              end
            end
          end

          READ: begin
            rbuf_q <= rbuf_d;
            cap_q  <= cap_d;
            if (lat_q && (cap_d == len_q)) begin
              state_q <= IDLE;
              pres_q  <= 1'b0;
              lat_q   <= 1'b0;
              if (owner_mem_q) begin
                mem_rdata_q <= rbuf_d;
                mem_done_q  <= 1'b1;
              end else begin
                if_rdata_q <= rbuf_d;
                if_done_q  <= 1'b1;
              end
            end else begin
              lat_q <= pres_q;
              if (issue_q < len_q) begin
                ram_a_q <= nxt_addr_c;
                issue_q <= issue_q + CNT_W'(1);
                pres_q  <= 1'b1;
              end else begin
                pres_q <= 1'b0;
              end
            end
          end

          WRITE: begin
            cap_q <= cap_d;
            if (cap_d == len_q) begin
              state_q    <= IDLE;
              mem_done_q <= 1'b1;
            end else begin
              ram_a_q    <= nxt_addr_c;
              ram_dout_q <= wdata_q[{issue_q[1:0], 3'b000} +: 8];
              ram_wr_q   <= 1'b1;
              issue_q    <= issue_q + CNT_W'(1);
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing steps, then random traffic with random
// pauses checked against a byte-array memory model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_if;

  // Power-on RAM contents, chosen per address for the directed steps
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101, 32'h0000_0102, 32'h0000_0103: return 8'h00;
      32'h0000_0104: return 8'h11;
      32'h0000_0105: return 8'h22;
      32'h0000_0106: return 8'h33;
      32'h0000_0107: return 8'h44;
      32'h0000_0030: return 8'h8F;
      32'hFFFF_FFFF: return 8'h5A;
      32'h0000_0000: return 8'hA5;
      default:       return a[7:0] ^ a[15:8] ^ 8'h5C;
    endcase
  endfunction

  // RAM model: synchronous read, byte valid the cycle after its address
  logic [7:0] ram [1024];
  bit         ram_vld [1024];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_vld[a[9:0]] ? ram[a[9:0]] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    bus.ram_din <= ram_rd(bus.ram_a);
    if (bus.ram_wr === 1'b1) begin
      ram[bus.ram_a[9:0]]     <= bus.ram_dout;
      ram_vld[bus.ram_a[9:0]] <= 1'b1;
    end
  end

  // Reference memory: what the requesters should see
  logic [7:0] ref_b [1024];
  bit         ref_v [1024];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_v[a[9:0]] ? ref_b[a[9:0]] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      ref_b[ai[9:0]] = d[8*i +: 8];
      ref_v[ai[9:0]] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dir_read(input string tag, input bit is_if, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] exp);
    int n;
    n = is_if ? 4 : nbytes(len);
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = len; bus.mem_addr = addr;
    end
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (k <= n) chk($sformatf("%s ram_a c%0d", tag, k), bus.ram_a, addr + 32'(k - 1));
      chk($sformatf("%s ram_wr c%0d", tag, k), 32'(bus.ram_wr), 32'd0);
      if (is_if) chk($sformatf("%s if_done c%0d", tag, k), 32'(bus.if_done), 32'(k == n + 2));
      else       chk($sformatf("%s mem_done c%0d", tag, k), 32'(bus.mem_done), 32'(k == n + 2));
      if (k == 1) begin
        bus.if_addr  = ~addr;
        bus.mem_addr = ~addr;
      end
      if (k == n + 2) begin
        if (is_if) begin
          chk({tag, " if_rdata"}, bus.if_rdata, exp);
          bus.if_req = 1'b0;
          last_if = exp;
        end else begin
          chk({tag, " mem_rdata"}, bus.mem_rdata, exp);
          bus.mem_req = 1'b0;
        end
      end
    end
  endtask

  task automatic dir_store(input string tag, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wd);
    int n;
    n = nbytes(len);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = len;
    bus.mem_addr = addr; bus.mem_wdata = wd;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      chk($sformatf("%s ram_wr c%0d", tag, k), 32'(bus.ram_wr), 32'(k <= n));
      if (k <= n) begin
        chk($sformatf("%s ram_a c%0d", tag, k), bus.ram_a, addr + 32'(k - 1));
        chk($sformatf("%s ram_dout c%0d", tag, k), 32'(bus.ram_dout), 32'(wd[8*(k-1) +: 8]));
      end
      chk($sformatf("%s mem_done c%0d", tag, k), 32'(bus.mem_done), 32'(k == n + 1));
      if (k == 1) bus.mem_wdata = ~wd;
      if (k == n + 1) bus.mem_req = 1'b0;
    end
  endtask

  // One random transaction (or an IF+MEM pair) under random rdy pauses
  task automatic run_txn(input bit do_if, input bit do_mem, input bit we, input logic [1:0] len,
                         input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
    logic [31:0] exp_if, exp_mem;
    bit if_p, mem_p;
    int n;
    n = nbytes(len);
    exp_mem = '0;
    if (do_mem) begin
      if (we) ref_store(ma, wd, n);
      else    exp_mem = ref_load(ma, n);
    end
    exp_if = ref_load(ia, 4);
    if_p  = do_if;
    mem_p = do_mem;
    bus.if_req = do_if; bus.if_addr = ia;
    bus.mem_req = do_mem; bus.mem_we = we; bus.mem_len = len;
    bus.mem_addr = ma; bus.mem_wdata = wd;
    bus.rdy = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < 300 && (if_p || mem_p); c++) begin
      @(negedge clk);
      if (bus.if_done === 1'b1) begin
        chk("rnd if_done owed", 32'(if_p), 32'd1);
        chk("rnd mem before if", 32'(mem_p), 32'd0);
        if (if_p) chk("rnd if_rdata", bus.if_rdata, exp_if);
        if_p = 1'b0;
        bus.if_req = 1'b0;
      end
      if (bus.mem_done === 1'b1) begin
        chk("rnd mem_done owed", 32'(mem_p), 32'd1);
        if (mem_p && !we) chk("rnd mem_rdata", bus.mem_rdata, exp_mem);
        mem_p = 1'b0;
        bus.mem_req = 1'b0;
      end
      bus.rdy = ($urandom_range(0, 3) != 0);
    end
    chk("rnd timeout", 32'({if_p, mem_p}), 32'd0);
    bus.rdy = 1'b1;
    @(negedge clk);
    chk("rnd done width", 32'({bus.if_done, bus.mem_done}), 32'd0);
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFFE + 32'($urandom_range(0, 3));
    return 32'h0000_0200 + 32'($urandom_range(0, 63));
  endfunction

  initial begin
    int got;
    bit do_if, do_mem, we;
    int op;
    logic [1:0] len;
    logic [31:0] ia, ma, wd;

    rst = 1'b1;
    bus.rdy = 1'b1; bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    last_if = '0;
    repeat (2) @(negedge clk);
    chk("rst ram_a", bus.ram_a, 32'd0);
    chk("rst ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst ram_dout", 32'(bus.ram_dout), 32'd0);
    chk("rst if_done", 32'(bus.if_done), 32'd0);
    chk("rst mem_done", 32'(bus.mem_done), 32'd0);
    chk("rst if_rdata", bus.if_rdata, 32'd0);
    chk("rst mem_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b0;

    dir_read("if_fetch", 1'b1, 32'h0000_0100, 2'd0, 32'h0000_0013);
    dir_store("st_word", 32'h0000_0020, 2'd2, 32'hAABB_CCDD);
    dir_store("st_byte", 32'h0000_0060, 2'd0, 32'h1234_5678);

    // Contention: MEM byte load served first, IF accepted at e3
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h0000_0030;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("cont mem_done c%0d", k), 32'(bus.mem_done), 32'(k == 3));
      chk($sformatf("cont if_done c%0d", k), 32'(bus.if_done), 32'(k == 9));
      if (k == 3) begin
        chk("cont mem_rdata", bus.mem_rdata, 32'h0000_008F);
        bus.mem_req = 1'b0;
      end
      if (k == 4) chk("cont if ram_a c4", bus.ram_a, 32'h0000_0100);
      if (k == 9) begin
        chk("cont if_rdata", bus.if_rdata, 32'h0000_0013);
        bus.if_req = 1'b0;
        last_if = 32'h0000_0013;
      end
    end

    // Flush in cycle 3 of a fetch; a MEM load raised alongside starts at e4
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0104;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("flush if_done c%0d", k), 32'(bus.if_done), 32'd0);
      chk($sformatf("flush mem_done c%0d", k), 32'(bus.mem_done), 32'(k == 7));
      if (k == 5) chk("flush mem ram_a c5", bus.ram_a, 32'h0000_0030);
      if (k == 7) begin
        chk("flush mem_rdata", bus.mem_rdata, 32'h0000_008F);
        bus.mem_req = 1'b0;
      end
      if (k == 3) begin
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd0; bus.mem_addr = 32'h0000_0030;
      end
      if (k == 4) bus.if_flush = 1'b0;
    end
    chk("flush if_rdata kept", bus.if_rdata, last_if);

    // rdy low during cycles 3-4 of a fetch
    got = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0104;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("pause ram_wr c%0d", k), 32'(bus.ram_wr), 32'd0);
      if (k == 6) chk("pause re-present c6", bus.ram_a, 32'h0000_0105);
      if (bus.if_done === 1'b1) begin
        got++;
        chk("pause if_rdata", bus.if_rdata, 32'h4433_2211);
        bus.if_req = 1'b0;
        last_if = 32'h4433_2211;
      end
      if (k == 3) bus.rdy = 1'b0;
      if (k == 5) bus.rdy = 1'b1;
    end
    chk("pause if_done count", 32'(got), 32'd1);

    // Reset at e2 of a word store
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h0000_0040; bus.mem_wdata = 32'h1122_3344;
    @(negedge clk);
    chk("rstw ram_wr c1", 32'(bus.ram_wr), 32'd1);
    @(negedge clk);
    rst = 1'b1; bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw ram_wr c3", 32'(bus.ram_wr), 32'd0);
    chk("rstw ram_a c3", bus.ram_a, 32'd0);
    chk("rstw ram_dout c3", 32'(bus.ram_dout), 32'd0);
    chk("rstw if_done c3", 32'(bus.if_done), 32'd0);
    chk("rstw mem_done c3", 32'(bus.mem_done), 32'd0);
    chk("rstw if_rdata c3", bus.if_rdata, 32'd0);
    chk("rstw mem_rdata c3", bus.mem_rdata, 32'd0);
    last_if = '0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("rstw mem_done c%0d", k), 32'(bus.mem_done), 32'd0);
    end
    dir_store("rstw next", 32'h0000_0050, 2'd2, 32'hCAFE_F00D);

    dir_read("wrap half", 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0000_A55A);

    // Random traffic with pauses against the reference memory
    for (int it = 0; it < 60; it++) begin
      op     = int'($urandom_range(0, 3));
      do_if  = (op == 0) || (op == 3);
      do_mem = (op != 0);
      we     = 1'($urandom_range(0, 1));
      len    = 2'($urandom_range(0, 3));
      ia     = pick_addr();
      ma     = pick_addr();
      wd     = $urandom();
      run_txn(do_if, do_mem, we, len, ia, ma, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
